// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common with the transmitter),
// data width and the parity helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity bit for a data byte (XOR reduce).
    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/receiver_if.sv
// Byte-side and serial-side signals of the UART receiver.
// slave: the receiver itself; master: the driver/consumer connected to it.
interface receiver_if;
    import uart_pkg::*;

    logic                      i_rx;
    logic [UART_DATA_BITS-1:0] o_data_byte;
    logic                      o_valid;
    logic                      o_parity_err;
    logic                      o_frame_err;
    logic                      o_active;

    modport slave (
        input  i_rx,
        output o_data_byte,
        output o_valid,
        output o_parity_err,
        output o_frame_err,
        output o_active
    );

    modport master (
        output i_rx,
        input  o_data_byte,
        input  o_valid,
        input  o_parity_err,
        input  o_frame_err,
        input  o_active
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input plus a
// falling-edge detector on the synchronized value. Reused on other async pins.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,      // asynchronous, active-low
    input  logic async_i,
    output logic rx_s_o,
    output logic fall_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain and one-cycle-delayed copy; all reset to idle-high
    // so no spurious edge is seen when reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/receiver.sv
// UART receive deframer: start, 8 data bits LSB first, even parity, stop.
// Optional build macro RX_MAJORITY_VOTE_EN: each bit is the majority of three
// consecutive samples around mid-bit, with the decision one cycle later.
module receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,     // asynchronous, active-low
    receiver_if.slave  bus
);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int VOTE_LAT = 1;
`else
    localparam int VOTE_LAT = 0;
`endif
    // Counter value at which the start bit is checked / a bit is taken.
    localparam logic [15:0] START_PT = 16'(HALF + VOTE_LAT);
    localparam logic [15:0] BIT_PT   = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX = 3'(UART_DATA_BITS - 1);

    logic rx_s;
    logic fall;
    logic bit_val;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (bus.i_rx),
        .rx_s_o  (rx_s),
        .fall_o  (fall)
    );

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] vote_q;

    // Keep the two previous synchronized samples for the 2-of-3 vote.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= {vote_q[0], rx_s};
        end
    end

    assign bit_val = (rx_s & vote_q[0]) | (rx_s & vote_q[1]) | (vote_q[0] & vote_q[1]);
`else
    assign bit_val = rx_s;
`endif

    uart_state_e               state_q, state_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      par_err_q, par_err_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      perr_out_q, perr_out_d;
    logic                      ferr_out_q, ferr_out_d;
    logic                      active_q, active_d;

    // State, bit timing and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            active_q   <= active_d;
        end
    end

    // Next-state logic: walk the frame bit by bit, sampling at mid-bit.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        active_d   = active_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                // Only a real 1->0 transition starts a frame; a held-low
                // line (break) is ignored until it rises and falls again.
                if (fall) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end
            START: begin
                if (cnt_q == START_PT) begin
                    cnt_d = '0;
                    if (!bit_val) begin
                        state_d = DATA;
                    end else begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_PT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = bit_val;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PARITY: begin
                if (cnt_q == BIT_PT) begin
                    cnt_d     = '0;
                    par_err_d = bit_val ^ uart_parity(shift_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                // Leave at mid-stop so the next start edge resynchronizes.
                if (cnt_q == BIT_PT) begin
                    cnt_d      = '0;
                    valid_d    = 1'b1;
                    data_d     = shift_q;
                    perr_out_d = par_err_q;
                    ferr_out_d = ~bit_val;
                    active_d   = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    assign bus.o_data_byte  = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_parity_err = perr_out_q;
    assign bus.o_frame_err  = ferr_out_q;
    assign bus.o_active     = active_q;

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for the UART receiver: frames are bit-banged onto i_rx,
// the expected byte/flags/valid cycle are queued, and a monitor compares on
// every o_valid. Honours RX_MAJORITY_VOTE_EN the same way as the design.
module tb_receiver;
    import uart_pkg::*;

    localparam int N = 10;
    localparam int H = (N - 1) / 2;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif
    // Pin driven low after posedge p -> edge detected in cycle p+2 (E),
    // o_valid in cycle E+H+10N+2 (+1 with voting).
    localparam int VALID_LAT = 2 + H + 10 * N + 2 + VOTE;
    localparam int NO_GLITCH = -100;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         vcyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    receiver_if rif ();

    receiver #(.CLKS_PER_BIT(N)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every o_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rif.o_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got o_valid=1 data=%02h, expected no frame (cycle %0d)",
                         rif.o_data_byte, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("data_byte",  32'(rif.o_data_byte),  32'(mon_e.data));
                check("parity_err", 32'(rif.o_parity_err), 32'(mon_e.perr));
                check("frame_err",  32'(rif.o_frame_err),  32'(mon_e.ferr));
                check("valid_cycle", cyc, mon_e.vcyc);
                $display("frame: data=%02h perr=%0b ferr=%0b at cycle %0d",
                         rif.o_data_byte, rif.o_parity_err, rif.o_frame_err, cyc);
            end
        end
    end

    // Bit-bang one frame; optionally queue the expected result. glitch_bit
    // selects a data bit that gets a one-cycle low pulse at its mid-point.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input bit expect_v, input logic exp_perr, input logic exp_ferr,
                              input int glitch_bit);
        logic [10:0] bits;
        exp_t        e;
        bits = {stp, par, d, 1'b0};
        @(posedge clk);
        #1;
        if (expect_v) begin
            e.data = d;
            e.perr = exp_perr;
            e.ferr = exp_ferr;
            e.vcyc = cyc + VALID_LAT;
            sb_q.push_back(e);
        end
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < N; c++) begin
                rif.i_rx = (b == glitch_bit + 1 && c == H + 1) ? 1'b0 : bits[b];
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle_bits(input int nbits);
        rif.i_rx = 1'b1;
        repeat (nbits * N) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] partial;
        rif.i_rx = 1'b1;
        reset    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid",  32'(rif.o_valid),      32'h0);
        check("reset_data",   32'(rif.o_data_byte),  32'h0);
        check("reset_perr",   32'(rif.o_parity_err), 32'h0);
        check("reset_ferr",   32'(rif.o_frame_err),  32'h0);
        check("reset_active", 32'(rif.o_active),     32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_bits(2);

        // Clean frame, with latency check via the scoreboard.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO_GLITCH);
        idle_bits(2);
        @(negedge clk);
        check("data_held", 32'(rif.o_data_byte), 32'hA5);

        // Parity bit forced wrong.
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, NO_GLITCH);
        idle_bits(2);

        // Stop bit low, then a 30-bit break: one frame, no more.
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, NO_GLITCH);
        rif.i_rx = 1'b0;
        repeat (30 * N) @(posedge clk);
        @(negedge clk);
        check("break_active", 32'(rif.o_active), 32'h0);
        idle_bits(2);

        // False start: 3-cycle low pulse.
        @(posedge clk);
        #1;
        rif.i_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rif.i_rx = 1'b1;
        @(negedge clk);
        check("false_start_active_hi", 32'(rif.o_active), 32'h1);
        repeat (20) @(negedge clk);
        check("false_start_active_lo", 32'(rif.o_active), 32'h0);
        idle_bits(2);

        // Back-to-back frames as the transmitter would send them.
        send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO_GLITCH);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO_GLITCH);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO_GLITCH);
        idle_bits(2);

        // Reset asserted in the middle of D4 of 0x77; frame must vanish.
        partial = 8'h77;
        @(posedge clk);
        #1;
        rif.i_rx = 1'b0;
        repeat (N) @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            #1;
            rif.i_rx = partial[b];
            repeat (N) @(posedge clk);
        end
        #1;
        rif.i_rx = partial[4];
        repeat (N / 2) @(posedge clk);
        #1;
        @(negedge clk);
        check("midframe_active", 32'(rif.o_active), 32'h1);
        reset = 1'b0;
        #1;
        check("abort_active", 32'(rif.o_active),    32'h0);
        check("abort_data",   32'(rif.o_data_byte), 32'h0);
        check("abort_valid",  32'(rif.o_valid),     32'h0);
        repeat (3) @(posedge clk);
        #1;
        rif.i_rx = 1'b1;
        reset    = 1'b1;
        idle_bits(3);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NO_GLITCH);
        idle_bits(2);

`ifdef RX_MAJORITY_VOTE_EN
        // One-cycle low glitch at mid-D3 must be voted out.
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
        idle_bits(2);
`endif

        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/receiver.md
# receiver

UART receive deframer: consumes the serial line produced by the team's `transmitter` block, recovers 8-bit LSB-first frames with even parity, and presents each byte with a one-cycle valid strobe and error flags. It sits between the FPGA RX pin and the byte-level consumer (loopback logic, command decoder). Frame format matches `transmitter` exactly: start(0), D0..D7, parity = XOR of D[7:0], stop(1).

## Interface
- `CLKS_PER_BIT`, 10: clk cycles per bit period; must be ≥ 8.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `i_rx`  in  1  serial line; asynchronous to clk, idles high
- `o_data_byte`  out  8  last received byte; held until next frame completes
- `o_valid`  out  1  one-cycle pulse per completed frame
- `o_parity_err`  out  1  parity mismatch on last frame; qualified by and updated with `o_valid`
- `o_frame_err`  out  1  stop bit sampled low on last frame; updated with `o_valid`
- `o_active`  out  1  high while a frame is being received

## Operation
- `i_rx` passes through a 2-flop synchronizer; reset value of both flops is 1. All logic below uses the synchronized value `rx_s` and its one-cycle-delayed copy.
- Define N = `CLKS_PER_BIT`, H = (N-1)/2 (integer division). 16-bit bit counter, 3-bit bit index.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: counter = 0, index = 0. Falling edge (previous `rx_s` = 1, current 0) → START, `o_active` ← 1. A line already low with no edge is not a start.
- START: count to H. At counter = H, if `rx_s` = 0 → DATA with counter 0; else false start → IDLE, `o_active` ← 0, no `o_valid`.
- DATA: at counter = N-1, shift sample into bit `index` (LSB first) and reset counter; after index 7 → PARITY.
- PARITY: at counter = N-1, store sample; `parity_err` = sample XOR (XOR of 8 data bits).
- STOP: at counter = N-1, sample stop bit. Next cycle: `o_valid` = 1, `o_data_byte` ← shift register, `o_parity_err` ← parity result, `o_frame_err` ← (stop sample == 0), `o_active` ← 0, state ← IDLE. Return to IDLE at mid-stop, so back-to-back frames are resynchronized on each start edge.
- `o_valid` pulses for every frame reaching the stop sample, including frames with errors. The byte is delivered even on error.
- Break (line held low after a framing error): no new frame starts until the line goes high and then falls again.

## Timing
- All outputs reset to 0 except: `o_data_byte` = 0x00, synchronizer flops = 1, state = IDLE.
- Let E be the cycle in which the falling edge is detected. Sampling points are at E+H+1+k·N for k = 1..10 (D0..D7, parity, stop). `o_valid` is high in cycle E+H+10N+2; with N = 10 that is E+106.
- Pin-to-detect latency: 2 cycles (synchronizer).
- Reset asserted mid-frame: outputs and FSM go to reset values immediately. The partial frame is discarded with no `o_valid`.
- Minimum accepted frame spacing: 10.5 bit periods from start edge to start edge.

## Configuration
- `RX_MAJORITY_VOTE_EN` defined: each bit value (start check included) is the majority of `rx_s` at counter positions mid-1, mid, mid+1. The decision is taken at mid+1, so every sample point and `o_valid` move one cycle later (E+107 at N = 10). A single-cycle glitch at mid-bit is rejected.
- Undefined: single sample at mid-bit as described above. No vote registers are synthesized.

## Structure
- Shared package `uart_pkg`: state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, common with `transmitter`), `UART_DATA_BITS` = 8, and the parity function (XOR reduce).
- One sub-module, `uart_rx_sync`: 2-flop synchronizer plus falling-edge detect, outputs `rx_s` and `fall`. This module is reused on other asynchronous inputs.

## Test plan
- Send 0xA5, parity 0, stop 1 → exactly one `o_valid`; `o_data_byte` = 0xA5; both error flags 0; `o_valid` at E+106 (N = 10).
- Send 0x3C with parity bit forced to 1 → `o_valid`; `o_data_byte` = 0x3C; `o_parity_err` = 1; `o_frame_err` = 0.
- Send 0x81 with stop bit 0, then hold the line low for 30 bit periods → one `o_valid` with `o_frame_err` = 1. No further `o_valid` until the line goes high and then falls.
- `i_rx` low for 3 cycles then high → `o_active` pulses, returns to 0 at the START check, no `o_valid`.
- `transmitter` looped back to `i_rx`, sending 0x00, 0xFF, 0x55 back-to-back → three `o_valid` pulses in order with correct bytes and no errors.
- `reset` asserted during D4 of a frame, released, then 0x5A sent → no `o_valid` for the aborted frame; 0x5A received cleanly. With `RX_MAJORITY_VOTE_EN` defined, a 1-cycle low glitch at mid-D3 of 0xFF is rejected.
